// File: rtl/lsu.sv
`default_nettype none
// lsu: imhotep load/store unit; one outstanding req/gnt/rvalid access with load extension and timeout.
// Optional macro IMHOTEP_LSU_MISALIGN_CHECK_EN: misaligned half/word requests fault instead of being force-aligned.
module lsu #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        dmem_req,
   input  logic        dmem_gnt,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  tmo_cnt;
   logic [1:0]  off_q;
   logic [1:0]  size_q;
   logic        uns_q;

   logic [1:0]  off;
   logic        illegal;
   logic [3:0]  be;
   logic [31:0] wdata_rep;
   logic [31:0] shifted;
   logic [31:0] ext;

   assign req_ready = (state == IDLE);

   // Request decode: lane offset (forced aligned when misalignment is tolerated), enables, replicated data.
   always_comb begin
      off       = addr[1:0];
      illegal   = 1'b0;
      be        = 4'b0000;
      wdata_rep = wdata;
      case (req_size)
         2'b00: begin
            be        = 4'b0001 << addr[1:0];
            wdata_rep = {4{wdata[7:0]}};
         end
         2'b01: begin
`ifdef IMHOTEP_LSU_MISALIGN_CHECK_EN
            illegal   = addr[0];
`endif
            off       = {addr[1], 1'b0};
            be        = 4'b0011 << {addr[1], 1'b0};
            wdata_rep = {2{wdata[15:0]}};
         end
         2'b10: begin
`ifdef IMHOTEP_LSU_MISALIGN_CHECK_EN
            illegal   = |addr[1:0];
`endif
            off       = 2'b00;
            be        = 4'b1111;
         end
         default: illegal = 1'b1;
      endcase
   end

   always_comb begin
      shifted = dmem_rdata >> {off_q, 3'b000};
      case (size_q)
         2'b00:   ext = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   ext = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         tmo_cnt    <= 8'd0;
         off_q      <= 2'b00;
         size_q     <= 2'b00;
         uns_q      <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_err   <= 1'b0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_be    <= 4'b0000;
         dmem_addr  <= 32'd0;
         dmem_wdata <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  resp_rdata <= 32'd0;
                  if (illegal) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state      <= REQ;
                     resp_err   <= 1'b0;
                     tmo_cnt    <= 8'd0;
                     dmem_req   <= 1'b1;
                     dmem_we    <= req_we;
                     dmem_be    <= be;
                     dmem_addr  <= {addr[31:2], 2'b00};
                     dmem_wdata <= wdata_rep;
                     off_q      <= off;
                     size_q     <= req_size;
                     uns_q      <= req_unsigned;
                  end
               end
            end
            REQ: begin
               if (dmem_gnt) begin
                  state    <= WAIT;
                  dmem_req <= 1'b0;
                  tmo_cnt  <= 8'd0;
               end else if (tmo_cnt == TMO_LAST) begin
                  state      <= RESP;
                  dmem_req   <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            WAIT: begin
               if (dmem_rvalid) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= dmem_err;
                  resp_rdata <= (dmem_err || dmem_we) ? 32'd0 : ext;
               end else if (tmo_cnt == TMO_LAST) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            default: begin
               state      <= IDLE;
               resp_err   <= 1'b0;
               resp_rdata <= 32'd0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// tb_lsu: randomized self-checking bench for lsu against a byte-lane reference model.
module tb_lsu;
   localparam int TO = 4;
   localparam int WIN = 2 * TO + 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [31:0] addr, wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        dmem_req, dmem_gnt, dmem_we, dmem_rvalid, dmem_err;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

   lsu #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .addr(addr), .wdata(wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;

   // Observations of the last transaction, cycle n = 1 is the cycle after acceptance.
   logic [3:0]  o_be;
   logic [31:0] o_addr, o_wdata, o_rdata;
   logic        o_we, o_err, o_ready_after, o_unstable;
   int          o_req_cycles, o_resp_cycle, o_resp_count;

   // Reference model results.
   logic        m_ill;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_rdata;

   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
      int nb, off;
      logic [31:0] mask, v;
      m_ill   = (size == 2'b11);
      m_addr  = a & 32'hFFFF_FFFC;
      m_be    = 4'b0000;
      m_wdata = 32'd0;
      m_rdata = 32'd0;
      if (!m_ill) begin
         nb  = 1 << size;
         off = int'(a[1:0]);
`ifdef IMHOTEP_LSU_MISALIGN_CHECK_EN
         if (off % nb != 0) m_ill = 1'b1;
`else
         off = off - (off % nb);
`endif
         m_be = 4'(((1 << nb) - 1) << off);
         for (int i = 0; i < 4; i++) m_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
         mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
         v = (rd >> (8 * off)) & mask;
         if (!uns && v[8*nb-1]) v = v | ~mask;
         m_rdata = we ? 32'd0 : v;
      end
   endtask

   task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input logic berr, input int gnt_wait, input int rv_wait);
      logic bus_on;
      model(we, size, uns, a, wd, rd);
      bus_on = !m_ill;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; addr = a; wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; addr = $urandom; wdata = $urandom;
      o_req_cycles = 0; o_resp_cycle = 0; o_resp_count = 0; o_unstable = 1'b0; o_ready_after = 1'b0;
      o_be = dmem_be; o_addr = dmem_addr; o_wdata = dmem_wdata; o_we = dmem_we;
      o_rdata = 'x; o_err = 1'bx;
      for (int n = 1; n <= WIN; n++) begin
         if (n > 1) @(negedge clk);
         dmem_gnt    = bus_on && (gnt_wait < TO) && (n == 1 + gnt_wait);
         dmem_rvalid = bus_on && (gnt_wait < TO) && (n == 2 + gnt_wait + rv_wait);
         dmem_rdata  = dmem_rvalid ? rd : $urandom;
         dmem_err    = dmem_rvalid ? berr : 1'($urandom % 2);
         if (dmem_req) begin
            o_req_cycles++;
            if ({dmem_be, dmem_addr, dmem_wdata, dmem_we} !== {o_be, o_addr, o_wdata, o_we}) o_unstable = 1'b1;
         end
         if (resp_valid) begin
            o_resp_count++;
            if (o_resp_cycle == 0) begin
               o_resp_cycle = n; o_rdata = resp_rdata; o_err = resp_err;
            end
         end
         if (o_resp_cycle != 0 && n == o_resp_cycle + 1) o_ready_after = req_ready;
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      nvec++;
      if ({resp_valid, resp_err, resp_rdata, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0) begin
         nerr++; $display("FAIL reset_outputs: got nonzero output, dmem_req=%b resp_valid=%b dmem_addr=%h", dmem_req, resp_valid, dmem_addr);
      end
      nvec++;
      if (req_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (req_ready !== 1'b1) begin nerr++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_loads;
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 0);
      nvec++; if (o_be !== 4'b1111) begin nerr++; $display("FAIL lw_be: got %b want 1111", o_be); end
      nvec++; if (o_resp_cycle !== 3) begin nerr++; $display("FAIL lw_latency: got T+%0d want T+3", o_resp_cycle); end
      nvec++; if (o_rdata !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL lw_rdata: got %h want deadbeef", o_rdata); end
      nvec++; if (o_err !== 1'b0) begin nerr++; $display("FAIL lw_err: got %b want 0", o_err); end
      nvec++; if (o_ready_after !== 1'b1) begin nerr++; $display("FAIL lw_ready_t4: got %b want 1", o_ready_after); end
      run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0);
      nvec++; if (o_be !== 4'b1000) begin nerr++; $display("FAIL lb_be: got %b want 1000", o_be); end
      nvec++; if (o_rdata !== 32'hFFFF_FF80) begin nerr++; $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
      run_txn(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 1'b0, 0, 0);
      nvec++; if (o_rdata !== 32'h0000_0080) begin nerr++; $display("FAIL lbu_rdata: got %h want 00000080", o_rdata); end
   endtask

   task automatic test_store;
      run_txn(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 32'h5555_AAAA, 1'b0, 1, 2);
      nvec++; if (o_addr !== 32'h0000_2000) begin nerr++; $display("FAIL sh_addr: got %h want 00002000", o_addr); end
      nvec++; if (o_be !== 4'b1100) begin nerr++; $display("FAIL sh_be: got %b want 1100", o_be); end
      nvec++; if (o_wdata !== 32'hABCD_ABCD) begin nerr++; $display("FAIL sh_wdata: got %h want abcdabcd", o_wdata); end
      nvec++; if (o_we !== 1'b1) begin nerr++; $display("FAIL sh_we: got %b want 1", o_we); end
      nvec++; if (o_rdata !== 32'd0 || o_err !== 1'b0) begin nerr++; $display("FAIL sh_resp: got rdata %h err %b want 0/0", o_rdata, o_err); end
   endtask

   task automatic test_misaligned;
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 0);
`ifdef IMHOTEP_LSU_MISALIGN_CHECK_EN
      nvec++; if (o_resp_cycle !== 1 || o_err !== 1'b1) begin nerr++; $display("FAIL lw_misalign_err: got T+%0d err %b want T+1 err 1", o_resp_cycle, o_err); end
      nvec++; if (o_req_cycles !== 0) begin nerr++; $display("FAIL lw_misalign_nobus: got %0d req cycles want 0", o_req_cycles); end
`else
      nvec++; if (o_addr !== 32'h0000_3000 || o_be !== 4'b1111) begin nerr++; $display("FAIL lw_misalign_bus: got %h/%b want 00003000/1111", o_addr, o_be); end
      nvec++; if (o_err !== 1'b0 || o_rdata !== 32'h0BAD_F00D) begin nerr++; $display("FAIL lw_misalign_resp: got %h err %b want 0badf00d err 0", o_rdata, o_err); end
`endif
      run_txn(1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 1'b0, 0, 0);
      nvec++; if (o_resp_cycle !== 1 || o_err !== 1'b1 || o_rdata !== 32'd0) begin nerr++; $display("FAIL illegal_size: got T+%0d err %b rdata %h want T+1 1 0", o_resp_cycle, o_err, o_rdata); end
      nvec++; if (o_req_cycles !== 0) begin nerr++; $display("FAIL illegal_size_nobus: got %0d req cycles want 0", o_req_cycles); end
   endtask

   task automatic test_timeout;
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 1'b0, 255, 0);
      nvec++; if (o_req_cycles !== TO) begin nerr++; $display("FAIL gnt_tmo_req_cycles: got %0d want %0d", o_req_cycles, TO); end
      nvec++; if (o_resp_cycle !== TO + 1 || o_err !== 1'b1) begin nerr++; $display("FAIL gnt_tmo_resp: got T+%0d err %b want T+%0d err 1", o_resp_cycle, o_err, TO + 1); end
      nvec++; if (o_ready_after !== 1'b1) begin nerr++; $display("FAIL gnt_tmo_ready: got %b want 1", o_ready_after); end
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4004, 32'h0, 32'h0, 1'b0, 0, 255);
      nvec++; if (o_resp_cycle !== 2 + TO || o_err !== 1'b1) begin nerr++; $display("FAIL rv_tmo_resp: got T+%0d err %b want T+%0d err 1", o_resp_cycle, o_err, 2 + TO); end
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_4008, 32'h0, 32'hCAFE_F00D, 1'b1, 1, 1);
      nvec++; if (o_err !== 1'b1 || o_rdata !== 32'd0) begin nerr++; $display("FAIL bus_err: got err %b rdata %h want 1 / 0", o_err, o_rdata); end
   endtask

   task automatic test_reset_in_wait;
      int seen;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; addr = 32'h0000_5000;
      @(negedge clk);
      req_valid = 1'b0; dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      #1 rst = 1'b1;
      #1;
      nvec++; if (dmem_req !== 1'b0 || req_ready !== 1'b1) begin nerr++; $display("FAIL async_reset: got req %b ready %b want 0/1", dmem_req, req_ready); end
      @(negedge clk);
      rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = $urandom; dmem_err = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         dmem_rvalid = 1'b0;
         if (resp_valid) seen++;
      end
      nvec++; if (seen !== 0) begin nerr++; $display("FAIL reset_wait_noresp: got %0d resp pulses want 0", seen); end
      nvec++;
      if ({resp_err, resp_rdata, dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata} !== '0 || req_ready !== 1'b1) begin
         nerr++; $display("FAIL reset_wait_outputs: got addr %h be %b ready %b want zeros and ready 1", dmem_addr, dmem_be, req_ready);
      end
   endtask

   task automatic test_random;
      logic        we, uns, berr, eerr;
      logic [1:0]  size;
      logic [31:0] a, wd, rd, erd;
      int gw, rw, erc, ereq;
      for (int k = 0; k < 80; k++) begin
         we   = 1'($urandom % 2);
         uns  = 1'($urandom % 2);
         size = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom % 3);
         a    = $urandom; wd = $urandom; rd = $urandom;
         berr = ($urandom % 6 == 0);
         gw   = $urandom_range(0, TO + 1);
         rw   = $urandom_range(0, TO + 1);
         run_txn(we, size, uns, a, wd, rd, berr, gw, rw);
         if (m_ill) begin erc = 1; ereq = 0; eerr = 1'b1; end
         else if (gw >= TO) begin erc = TO + 1; ereq = TO; eerr = 1'b1; end
         else if (rw >= TO) begin erc = gw + 2 + TO; ereq = gw + 1; eerr = 1'b1; end
         else begin erc = gw + 3 + rw; ereq = gw + 1; eerr = berr; end
         erd = eerr ? 32'd0 : m_rdata;
         nvec++; if (o_resp_cycle !== erc || o_resp_count !== 1) begin nerr++; $display("FAIL rnd%0d_resp_timing: got T+%0d x%0d want T+%0d x1", k, o_resp_cycle, o_resp_count, erc); end
         nvec++; if (o_err !== eerr || o_rdata !== erd) begin nerr++; $display("FAIL rnd%0d_resp_data: got %h err %b want %h err %b", k, o_rdata, o_err, erd, eerr); end
         nvec++; if (o_req_cycles !== ereq) begin nerr++; $display("FAIL rnd%0d_req_cycles: got %0d want %0d", k, o_req_cycles, ereq); end
         nvec++; if (o_ready_after !== 1'b1) begin nerr++; $display("FAIL rnd%0d_ready: got %b want 1", k, o_ready_after); end
         if (!m_ill) begin
            nvec++;
            if ({o_be, o_addr, o_wdata, o_we} !== {m_be, m_addr, m_wdata, we} || o_unstable) begin
               nerr++; $display("FAIL rnd%0d_bus: got be %b addr %h wd %h we %b unstable %b want %b %h %h %b", k, o_be, o_addr, o_wdata, o_we, o_unstable, m_be, m_addr, m_wdata, we);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
      addr = 32'd0; wdata = 32'd0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0; dmem_err = 1'b0;
      test_reset();
      test_loads();
      test_store();
      test_misaligned();
      test_timeout();
      test_reset_in_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
